// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths and grant encodings for the register-file write-back path.
package rf_wb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_REGS   = 2**DEF_ADDR_W;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REQ0 = 2'd1,
    GNT_REQ1 = 2'd2
  } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bitmap, reservation error pulse and RAW hazard detect.
// With RF_WB_BYPASS_EN, sources matching the in-flight write are forwarded instead.
module rf_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ADDR_W-1:0]    chk_addr1,
  input  logic [ADDR_W-1:0]    chk_addr2,
`ifdef RF_WB_BYPASS_EN
  output logic                 byp_hit1,
  output logic                 byp_hit2,
`endif
  output logic                 rsv_err,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NR = 2**ADDR_W;

  logic [NR-1:0] set_vec;
  logic [NR-1:0] clr_vec;
  logic          clr_hit;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_valid) set_vec[rsv_addr] = 1'b1;
    if (wr_en)     clr_vec[wr_addr]  = 1'b1;
  end

  assign clr_hit = wr_en && (wr_addr == rsv_addr);

  // Set is applied after clear so a same-edge reserve wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      rsv_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      rsv_err <= rsv_valid && pending[rsv_addr] && !clr_hit;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1 = wr_en && (wr_addr == chk_addr1);
  assign byp_hit2 = wr_en && (wr_addr == chk_addr2);
  assign hazard   = (pending[chk_addr1] && !byp_hit1)
                 || (pending[chk_addr2] && !byp_hit2);
`else
  assign hazard = pending[chk_addr1] || pending[chk_addr2];
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester write-back arbiter driving the register-file write port.
// Optional RF_WB_BYPASS_EN adds byp_hit1/byp_hit2/byp_data forwarding outputs.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  input  logic                 rsv_valid,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic                 rsv_err,
  input  logic [ADDR_W-1:0]    chk_addr1,
  input  logic [ADDR_W-1:0]    chk_addr2,
  output logic                 hazard,
`ifdef RF_WB_BYPASS_EN
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [DATA_W-1:0]    byp_data,
`endif
  output logic [2**ADDR_W-1:0] pending,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  gnt_e       gnt;
  logic [2:0] starve_cnt;
  logic [2:0] starve_nxt;

  // req1 only beats a valid req0 once it has lost LIMIT times in a row.
  always_comb begin
    gnt = GNT_NONE;
    if (req1_valid && (!req0_valid || starve_cnt == LIMIT))
      gnt = GNT_REQ1;
    else if (req0_valid)
      gnt = GNT_REQ0;
  end

  assign req0_ready = (gnt == GNT_REQ0);
  assign req1_ready = (gnt == GNT_REQ1);

  always_comb begin
    starve_nxt = '0;
    if (req1_valid && gnt == GNT_REQ0)
      starve_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      starve_cnt <= '0;
    end else begin
      rf_we      <= (gnt != GNT_NONE);
      starve_cnt <= starve_nxt;
      unique case (gnt)
        GNT_REQ0: begin
          rf_waddr <= req0_addr;
          rf_wdata <= req0_data;
        end
        GNT_REQ1: begin
          rf_waddr <= req1_addr;
          rf_wdata <= req1_data;
        end
        default: ;
      endcase
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_data = rf_wdata;
`endif

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .wr_en    (rf_we),
    .wr_addr  (rf_waddr),
    .chk_addr1(chk_addr1),
    .chk_addr2(chk_addr2),
`ifdef RF_WB_BYPASS_EN
    .byp_hit1 (byp_hit1),
    .byp_hit2 (byp_hit2),
`endif
    .rsv_err  (rsv_err),
    .hazard   (hazard),
    .pending  (pending)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table, starvation and reset sequences,
// then constrained-random traffic against a behavioural scoreboard model.
module tb_rf_wb_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = rf_wb_pkg::NUM_REGS;
  localparam int SL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          rsv_err;
  logic [AW-1:0] chk_addr1 = '0;
  logic [AW-1:0] chk_addr2 = '0;
  logic          hazard;
  logic [NR-1:0] pending;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
  logic          byp_hit1;
  logic          byp_hit2;
  logic [DW-1:0] byp_data;
`endif

  rf_wb_arbiter #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_err   (rsv_err),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .hazard    (hazard),
`ifdef RF_WB_BYPASS_EN
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data  (byp_data),
`endif
    .pending   (pending),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: pending set as a bit array, loss streak as an int.
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [NR-1:0] m_pend;
  logic          m_err;
  int            m_lose;

  task automatic m_reset();
    m_we = 0; m_wa = '0; m_wd = '0;
    m_pend = '0; m_err = 0; m_lose = 0;
  endtask

  function automatic logic m_g1();
    return req1_valid && (!req0_valid || m_lose >= SL);
  endfunction

  function automatic logic m_g0();
    return req0_valid && !m_g1();
  endfunction

  function automatic logic m_hz();
    logic h1, h2;
    h1 = m_pend[chk_addr1];
    h2 = m_pend[chk_addr2];
`ifdef RF_WB_BYPASS_EN
    if (m_we && m_wa == chk_addr1) h1 = 0;
    if (m_we && m_wa == chk_addr2) h2 = 0;
`endif
    return h1 | h2;
  endfunction

  task automatic m_edge();
    logic g0, g1;
    logic [NR-1:0] np;
    g0 = m_g0();
    g1 = m_g1();
    np = m_pend;
    if (m_we) np[m_wa] = 0;
    m_err = 0;
    if (rsv_valid) begin
      m_err = m_pend[rsv_addr] && !(m_we && m_wa == rsv_addr);
      np[rsv_addr] = 1;
    end
    m_pend = np;
    if (!req1_valid || g1) m_lose = 0;
    else if (g0) m_lose = (m_lose < SL) ? m_lose + 1 : SL;
    m_we = g0 || g1;
    if (g1) begin m_wa = req1_addr; m_wd = req1_data; end
    else if (g0) begin m_wa = req0_addr; m_wd = req0_data; end
  endtask

  task automatic mtick();
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(m_g0()));
    chk("req1_ready", 32'(req1_ready), 32'(m_g1()));
    chk("hazard", 32'(hazard), 32'(m_hz()));
`ifdef RF_WB_BYPASS_EN
    chk("byp_hit1", 32'(byp_hit1), 32'(m_we && m_wa == chk_addr1));
    if (byp_hit1) chk("byp_data", 32'(byp_data), 32'(m_wd));
`endif
    @(posedge clk);
    m_edge();
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_wa));
      chk("rf_wdata", 32'(rf_wdata), 32'(m_wd));
    end
    chk("pending", 32'(pending), 32'(m_pend));
    chk("rsv_err", 32'(rsv_err), 32'(m_err));
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
  endtask

  typedef struct {
    logic          r0v;
    logic [AW-1:0] r0a;
    logic [DW-1:0] r0d;
    logic          r1v;
    logic [AW-1:0] r1a;
    logic [DW-1:0] r1d;
    logic          rv;
    logic [AW-1:0] ra;
    logic [AW-1:0] c1;
    logic [AW-1:0] c2;
    logic          e0;
    logic          e1;
    logic          ehz;
    logic          ehzb;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          err;
    logic [NR-1:0] pend;
  } vec_t;

  vec_t vec[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1;
    int   n1;
    logic exp_hz;

    vec[0]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0000};
    vec[1]  = '{1'b1,4'd3,16'h1234, 1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd0,4'd0, 1'b1,1'b0,1'b0,1'b0,
                1'b1,4'd3,16'h1234, 1'b0,16'h0000};
    vec[2]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0000};
    vec[3]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b1,4'd5,
                4'd5,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0020};
    vec[4]  = '{1'b0,4'd0,16'h0,    1'b1,4'd5,16'h0BEE, 1'b0,4'd0,
                4'd5,4'd0, 1'b0,1'b1,1'b1,1'b1,
                1'b1,4'd5,16'h0BEE, 1'b0,16'h0020};
    vec[5]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd5,4'd0, 1'b0,1'b0,1'b1,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0000};
    vec[6]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd5,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0000};
    vec[7]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b1,4'd7,
                4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0080};
    vec[8]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b1,4'd7,
                4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b1,16'h0080};
    vec[9]  = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0080};
    vec[10] = '{1'b1,4'd9,16'h0009, 1'b0,4'd0,16'h0,    1'b1,4'd9,
                4'd0,4'd0, 1'b1,1'b0,1'b0,1'b0,
                1'b1,4'd9,16'h0009, 1'b0,16'h0280};
    vec[11] = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b1,4'd9,
                4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0280};
    vec[12] = '{1'b1,4'd2,16'hAAAA, 1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd0,4'd0, 1'b1,1'b0,1'b0,1'b0,
                1'b1,4'd2,16'hAAAA, 1'b0,16'h0280};
    vec[13] = '{1'b0,4'd0,16'h0,    1'b1,4'd2,16'h5555, 1'b0,4'd0,
                4'd0,4'd0, 1'b0,1'b1,1'b0,1'b0,
                1'b1,4'd2,16'h5555, 1'b0,16'h0280};
    vec[14] = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd7,4'd9, 1'b0,1'b0,1'b1,1'b1,
                1'b0,4'd0,16'h0,    1'b0,16'h0280};
    vec[15] = '{1'b0,4'd0,16'h0,    1'b0,4'd0,16'h0,    1'b0,4'd0,
                4'd1,4'd2, 1'b0,1'b0,1'b0,1'b0,
                1'b0,4'd0,16'h0,    1'b0,16'h0280};

    // Reset values while reset is held.
    #12;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_rsv_err", 32'(rsv_err), 32'd0);
    reset = 0;
    m_reset();

    for (int i = 0; i < 5; i++) mtick();

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      req0_valid = vec[i].r0v; req0_addr = vec[i].r0a; req0_data = vec[i].r0d;
      req1_valid = vec[i].r1v; req1_addr = vec[i].r1a; req1_data = vec[i].r1d;
      rsv_valid = vec[i].rv; rsv_addr = vec[i].ra;
      chk_addr1 = vec[i].c1; chk_addr2 = vec[i].c2;
`ifdef RF_WB_BYPASS_EN
      exp_hz = vec[i].ehzb;
`else
      exp_hz = vec[i].ehz;
`endif
      #1;
      chk($sformatf("v%0d_r0rdy", i), 32'(req0_ready), 32'(vec[i].e0));
      chk($sformatf("v%0d_r1rdy", i), 32'(req1_ready), 32'(vec[i].e1));
      chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(exp_hz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vec[i].we));
      if (vec[i].we) begin
        chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vec[i].wa));
        chk($sformatf("v%0d_wdata", i), 32'(rf_wdata), 32'(vec[i].wd));
      end
      chk($sformatf("v%0d_err", i), 32'(rsv_err), 32'(vec[i].err));
      chk($sformatf("v%0d_pend", i), 32'(pending), 32'(vec[i].pend));
    end

    // Both requesters held valid: req1 wins once every SL+1 cycles.
    idle();
    chk_addr1 = 4'd0; chk_addr2 = 4'd0;
    req0_valid = 1; req0_addr = 4'd1; req0_data = 16'h1111;
    req1_valid = 1; req1_addr = 4'd4; req1_data = 16'h4444;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("st%0d_r1rdy", i), 32'(req1_ready), 32'((i % 4) == 3));
      chk($sformatf("st%0d_r0rdy", i), 32'(req0_ready), 32'((i % 4) != 3));
      if (req1_ready) n1++;
      @(posedge clk);
      #1;
      chk($sformatf("st%0d_we", i), 32'(rf_we), 32'd1);
      chk($sformatf("st%0d_waddr", i), 32'(rf_waddr),
          ((i % 4) == 3) ? 32'd4 : 32'd1);
    end
    chk("st_r1_grants", 32'(n1), 32'd2);

    // Reset while a write is registered: drops without a clock edge.
    idle();
    chk("mid_we_before", 32'(rf_we), 32'd1);
    reset = 1;
    #1;
    chk("mid_we_async", 32'(rf_we), 32'd0);
    chk("mid_pend_async", 32'(pending), 32'd0);
    #1;
    reset = 0;
    m_reset();

    // Randomised traffic; requesters hold until granted.
    g0 = 1; g1 = 1;
    for (int i = 0; i < 1500; i++) begin
      if (!req0_valid || g0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = 4'($urandom);
        req0_data  = 16'($urandom);
      end
      if (!req1_valid || g1) begin
        req1_valid = ($urandom_range(0, 1) != 0);
        req1_addr  = 4'($urandom);
        req1_data  = 16'($urandom);
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 4'($urandom);
      chk_addr1 = 4'($urandom);
      chk_addr2 = 4'($urandom);
      g0 = m_g0();
      g1 = m_g1();
      mtick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back controller for the 16x16 register file's single write port. It arbitrates between two write-back requesters: req0 is the ALU path, and req1 is the load/multi-cycle path. The winning write is registered and drives the register file's RegWrite/write_register/write_data inputs. It also holds a pending-write scoreboard so decode can stall on read-after-write hazards against in-flight writes.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register index width; NUM_REGS = 2**ADDR_W
STARVE_LIMIT, 3, consecutive cycles req1 may lose before it is force-granted (range 1..7)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req0_valid  in  1  ALU write-back request
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req0_ready  out  1  req0 granted this cycle (combinational)
req1_valid  in  1  load/multi-cycle write-back request
req1_addr  in  ADDR_W  destination register
req1_data  in  DATA_W  result
req1_ready  out  1  req1 granted this cycle (combinational)
rsv_valid  in  1  decode reserves a destination register
rsv_addr  in  ADDR_W  register being reserved
rsv_err  out  1  registered pulse: reservation hit an already-pending register
chk_addr1  in  ADDR_W  decode source operand 1
chk_addr2  in  ADDR_W  decode source operand 2
hazard  out  1  combinational: either source is pending
pending  out  NUM_REGS  scoreboard bitmap (registered)
rf_we  out  1  to register file RegWrite (registered)
rf_waddr  out  ADDR_W  to write_register (registered)
rf_wdata  out  DATA_W  to write_data (registered)

Behaviour:
- Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, rsv_err=0, starve_cnt=0. Outputs hold these values until the first clock edge after reset deasserts.
- Handshake: a transfer occurs when reqN_valid && reqN_ready. Requesters hold valid/addr/data stable until ready is seen. ready never depends on a requester's own ready.
- Grant, fixed priority with a starvation override:
  - req1 wins if req1_valid && (!req0_valid || starve_cnt == STARVE_LIMIT); otherwise req0 wins if req0_valid.
  - At most one grant per cycle. No grant when neither request is valid.
- starve_cnt (3 bits):
  - increments when req1_valid and req0 is granted;
  - clears when req1 is granted or req1_valid is low;
  - saturates at STARVE_LIMIT.
- Write latency is 1 cycle. At the edge after a grant: rf_we=1, rf_waddr/rf_wdata = the winner's addr/data. The register file commits at the following edge.
- rf_we deasserts in the first cycle with no grant. Back-to-back grants produce rf_we high every cycle.
- Scoreboard:
  - rsv_valid sets pending[rsv_addr] at the next edge.
  - The edge at which rf_we=1 clears pending[rf_waddr]; this is the same edge the register file commits.
  - Set and clear of the same register at the same edge: set wins.
  - rsv_valid on a register already pending, and not being cleared that edge: the bit stays set and rsv_err pulses for one cycle.
- Write with no reservation: the register file is still written; clearing an already-0 bit is harmless.
- hazard = pending[chk_addr1] | pending[chk_addr2]. It stays high through the rf_we cycle, because the register file still returns the old value in that cycle.
- Both requesters may target the same register. Writes commit in grant order; the last grant wins the register file.
- Reset mid-transfer: any registered write is dropped (rf_we=0) and all reservations are lost. Upstream must reissue.

Optional Feature:
RF_WB_BYPASS_EN
- Defined:
  - adds outputs byp_hit1, byp_hit2 (1 bit each) and byp_data (DATA_W);
  - byp_hitN = rf_we && rf_waddr == chk_addrN;
  - byp_data = rf_wdata;
  - a source with a bypass hit is excluded from hazard, so decode uses the forwarded value.
- Undefined: these ports are absent and hazard behaves as described above.

Decomposition:
- Package rf_wb_pkg holds DATA_W/ADDR_W defaults, NUM_REGS, and the grant-select constants GNT_NONE, GNT_REQ0, GNT_REQ1.
- One sub-module, rf_scoreboard: the pending bitmap, set/clear priority, rsv_err and hazard/bypass logic.
- Arbitration and the write register stay in the top module.

Test Plan:
- Reset, then idle: rf_we=0, pending=0, hazard=0 for 5 cycles. Assert reset mid-write: rf_we drops immediately, without waiting for a clock edge.
- req0 only, addr=3, data=0x1234: req0_ready=1 the same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; following cycle rf_we=0.
- req0 and req1 both held valid continuously, STARVE_LIMIT=3: grant sequence req0,req0,req0,req1,req0,req0,req0,req1; req1_ready is high exactly once every 4 cycles.
- rsv_valid addr=5; later req1 writes addr 5 with chk_addr1=5: hazard=1 from the reservation through the rf_we cycle, and 0 the cycle after. With RF_WB_BYPASS_EN defined: byp_hit1=1 and hazard=0 in the rf_we cycle.
- rsv_valid addr=7 twice without a write in between: second reservation gives rsv_err=1 for one cycle, pending[7] stays 1. Reserve addr 9 on the same edge a write clears 9: pending[9]=1, rsv_err=0.
- req0 addr=2 data=0xAAAA granted in cycle N, req1 addr=2 data=0x5555 granted in cycle N+1: consecutive rf_we pulses, and rf_wdata sequence is 0xAAAA then 0x5555.
